rr_ring_arbiter: RTL and testbench

Round-robin arbiter that shares one resource among N requesters, with a one-hot ring-counter priority pointer. Grants are one-hot, registered and bounded in length. Each grant lasts until the owner drops its request or a hold limit expires. The pointer then rotates past the owner, so every active requester is served within N grants. It sits between the request sources and the shared datapath, and drives the resource select.

---
 rtl/rr_ring_arbiter_pkg.sv | 26 ++
 rtl/rr_ring_arbiter_if.sv | 16 +
 rtl/ring_priority_pick.sv | 23 ++
 rtl/rr_ring_arbiter.sv | 94 +++++++++
 tb/tb_rr_ring_arbiter.sv | 114 +++++++++++
 5 files changed

// File: rtl/rr_ring_arbiter_pkg.sv
// Shared types and helpers for the round-robin ring arbiter.
// Covers the FSM state type, the pointer reset value and one-hot decoding.
package rr_arb_pkg;

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  // Widest requester vector the helpers below can handle.
  localparam int unsigned MAX_N = 32;

  // After reset, priority starts at requester 0.
  localparam logic [MAX_N-1:0] PTR_RST = {{(MAX_N-1){1'b0}}, 1'b1};

  // OR-reduction decoder; assumes a one-hot or all-zero input.
  function automatic logic [4:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_ring_arbiter_if.sv
// Request/grant bundle between the request sources and the arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface rr_ring_arbiter_if #(
  parameter int N = 4
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]   req;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic [N-1:0]   ptr;

  modport master (output req, input grant, grant_id, busy, ptr);
  modport slave  (input req, output grant, grant_id, busy, ptr);
endinterface

// File: rtl/ring_priority_pick.sv
// Combinational circular priority pick: the first set req bit at or above the
// one-hot start position wins, wrapping from N-1 back to 0.
module ring_priority_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] start,
  output logic [N-1:0] winner,
  output logic         found
);
  localparam logic [N-1:0]   ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [2*N-1:0] ONE2 = {{(2*N-1){1'b0}}, 1'b1};

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] lowest;

  // Lower copy keeps only bits at or above start; the upper copy supplies the wrap.
  assign dbl    = {req, req & ~(start - ONE)};
  assign lowest = dbl & (~dbl + ONE2);
  assign winner = lowest[N-1:0] | lowest[2*N-1:N];
  assign found  = |req;

endmodule

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with a one-hot ring pointer and a bounded hold time.
// Grants are registered; a release hands over to the next winner with no idle gap.
module rr_ring_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input logic               clk,
  input logic               rst,
  rr_ring_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(N);
  localparam int HW  = $clog2(MAX_HOLD + 1);

  state_t         state;
  logic [HW-1:0]  hold_cnt;
  logic [N-1:0]   grant_q;
  logic [IDW-1:0] id_q;
  logic           busy_q;
  logic [N-1:0]   ptr_q;

  logic [N-1:0]   owner_next;
  logic [N-1:0]   start;
  logic [N-1:0]   winner;
  logic [IDW-1:0] win_id;
  logic           found;
  logic           rel;

  // NOTE: every signal gets a value on every path through this block, so no latch is inferred.
  always_comb begin
    owner_next = {grant_q[N-2:0], grant_q[N-1]};
    start      = (state == OWNED) ? owner_next : ptr_q;
    rel        = (state == OWNED) &&
                 (!(|(bus.req & grant_q)) || (hold_cnt == HW'(MAX_HOLD)));
    win_id     = IDW'(onehot_to_idx(MAX_N'(winner)));
  end

  ring_priority_pick #(.N(N)) u_pick (
    .req    (bus.req),
    .start  (start),
    .winner (winner),
    .found  (found)
  );

  // NOTE: non-blocking assignments throughout, so each register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      grant_q  <= '0;
      id_q     <= '0;
      busy_q   <= 1'b0;
      ptr_q    <= PTR_RST[N-1:0];
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state    <= OWNED;
            hold_cnt <= HW'(1);
            grant_q  <= winner;
            id_q     <= win_id;
            busy_q   <= 1'b1;
          end
        end
        OWNED: begin
          if (rel) begin
            ptr_q <= owner_next;
            if (found) begin
              hold_cnt <= HW'(1);
              grant_q  <= winner;
              id_q     <= win_id;
            end else begin
              state    <= IDLE;
              hold_cnt <= '0;
              grant_q  <= '0;
              id_q     <= '0;
              busy_q   <= 1'b0;
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = id_q;
  assign bus.busy     = busy_q;
  assign bus.ptr      = ptr_q;

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Table-driven bench for rr_ring_arbiter (N=4, MAX_HOLD=8): each record is one
// clock edge of stimulus with the grant and pointer expected after that edge.
module tb_rr_ring_arbiter;
  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rr_ring_arbiter_if #(.N(N)) bus ();

  rr_ring_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic         rst_v;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic [N-1:0] ptr;
  } vec_t;

  typedef struct {
    logic [N-1:0] grant;
    logic [1:0]   id;
    logic         busy;
    logic [N-1:0] ptr;
    int           tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @vec%0d: got %0h, expected %0h", name, tag, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [N-1:0] q, input logic [N-1:0] g,
                     input logic [N-1:0] p, input int reps);
    for (int k = 0; k < reps; k++) vecs.push_back('{rst_v: r, req: q, grant: g, ptr: p});
  endtask

  function automatic logic [1:0] idx_of(input logic [N-1:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < N; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;

    // Reset held with all requests pending.
    add(1'b0, 4'b1111, 4'b0000, 4'b0001, 2);
    // Full contention: each owner exactly MAX_HOLD cycles, pointer follows the grant.
    for (int k = 0; k < 40; k++) begin
      logic [N-1:0] g;
      g = 4'b0001 << ((k / MAX_HOLD) % N);
      add(1'b1, 4'b1111, g, g, 1);
    end
    // Sole requester 2: re-granted on every hold-limit release.
    add(1'b1, 4'b0100, 4'b0100, 4'b0010, 8);
    add(1'b1, 4'b0100, 4'b0100, 4'b1000, 12);
    // Early release: requester 0 drops during its third grant cycle.
    add(1'b1, 4'b0011, 4'b0001, 4'b1000, 3);
    add(1'b1, 4'b0010, 4'b0010, 4'b0010, 1);
    // Wrap-around: owner 3 hits the hold limit with req=1001, then everything idles.
    add(1'b1, 4'b1000, 4'b1000, 4'b0100, 1);
    add(1'b1, 4'b1001, 4'b1000, 4'b0100, 7);
    add(1'b1, 4'b1001, 4'b0001, 4'b0001, 1);
    add(1'b1, 4'b0000, 4'b0000, 4'b0010, 2);
    // Reset during the fifth cycle of a grant to requester 2.
    add(1'b1, 4'b0100, 4'b0100, 4'b0010, 5);
    add(1'b0, 4'b0100, 4'b0000, 4'b0001, 1);
    add(1'b1, 4'b0110, 4'b0010, 4'b0001, 1);

    bus.req = '0;
    rst     = 1'b0;
    foreach (vecs[i]) begin
      @(negedge clk);
      rst     = vecs[i].rst_v;
      bus.req = vecs[i].req;
      sb.push_back('{grant: vecs[i].grant, id: idx_of(vecs[i].grant),
                     busy: |vecs[i].grant, ptr: vecs[i].ptr, tag: i});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("grant",    e.tag, 32'(bus.grant),    32'(e.grant));
      check("grant_id", e.tag, 32'(bus.grant_id), 32'(e.id));
      check("busy",     e.tag, 32'(bus.busy),     32'(e.busy));
      check("ptr",      e.tag, 32'(bus.ptr),      32'(e.ptr));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
